iter_muldiv: RTL

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in EX beside the single-cycle ALU.
- Accepts MULT/MULTU/DIV/DIVU requests via a start pulse and iterates one bit per cycle (shift-add multiply, restoring divide).
- Writes the double-width result into HI/LO and signals completion.
- Supports pipeline flush and MTHI/MTLO writes.

---
 rtl/iter_muldiv.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
module iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_div,
   input  logic             sign,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             accept, abort, last_step;

   logic             op_div_p0, neg_lo_p0, neg_hi_p0, dz_p0;
   logic [WIDTH-1:0] opb_p0, a_orig_p0, low_p0;
   logic [WIDTH:0]   rem_p0;

   logic [WIDTH:0]     mul_sum, div_shift, div_opb;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
      logic signed [WIDTH-1:0] m;
      m = (is_signed && v < 0) ? -v : v;
      return $unsigned(m);
   endfunction

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
      return en ? -v : v;
   endfunction

   // Any MTHI/MTLO write while busy squashes the operation just like a flush.
   assign accept    = (state == S_IDLE) && start && !flush;
   assign abort     = flush || hi_we || lo_we;
   assign last_step = (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_CALC;
         S_CALC: begin
            if (abort)          state_nxt = S_IDLE;
            else if (last_step) state_nxt = S_FIX;
         end
         S_FIX:  state_nxt = abort ? S_IDLE : S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == S_CALC) || (state == S_FIX);
      done     = (state == S_DONE);
      div_zero = (state == S_DONE) && dz_p0;
   end

   always_ff @(posedge clk) begin
      if (rst)                   cnt <= '0;
      else if (accept)           cnt <= CNT_W'(WIDTH);
      else if (state == S_CALC)  cnt <= cnt - CNT_W'(1);
   end

   // Iteration datapath: rem_p0 is the product high half / partial remainder,
   // low_p0 is the multiplier shifting out / dividend shifting into quotient.
   assign mul_sum   = rem_p0 + (low_p0[0] ? {1'b0, opb_p0} : '0);
   assign div_shift = {rem_p0[WIDTH-1:0], low_p0[WIDTH-1]};
   assign div_opb   = {1'b0, opb_p0};

   always_ff @(posedge clk) begin
      if (accept) begin
         op_div_p0 <= op_div;
         dz_p0     <= op_div && (src_b == '0);
         neg_lo_p0 <= sign && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
         neg_hi_p0 <= sign && (op_div ? src_a[WIDTH-1] : (src_a[WIDTH-1] ^ src_b[WIDTH-1]));
         a_orig_p0 <= src_a;
         opb_p0    <= magnitude($signed(src_b), sign);
         low_p0    <= magnitude($signed(src_a), sign);
         rem_p0    <= '0;
      end else if (state == S_CALC) begin
         if (!op_div_p0) begin
            rem_p0 <= {1'b0, mul_sum[WIDTH:1]};
            low_p0 <= {mul_sum[0], low_p0[WIDTH-1:1]};
         end else if (div_shift >= div_opb) begin
            rem_p0 <= div_shift - div_opb;
            low_p0 <= {low_p0[WIDTH-2:0], 1'b1};
         end else begin
            rem_p0 <= div_shift;
            low_p0 <= {low_p0[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Sign fix applied to the unsigned magnitudes during FIX.
   assign prod_fix = neg_2w({rem_p0[WIDTH-1:0], low_p0}, neg_lo_p0);

   always_comb begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
      if (op_div_p0) begin
         if (dz_p0) begin
            fix_hi = a_orig_p0;
            fix_lo = '1;
         end else begin
            fix_hi = neg_w(rem_p0[WIDTH-1:0], neg_hi_p0);
            fix_lo = neg_w(low_p0, neg_lo_p0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (hi_we)                         hi <= wdata;
         else if (state == S_FIX && !abort) hi <= fix_hi;
         if (lo_we)                         lo <= wdata;
         else if (state == S_FIX && !abort) lo <= fix_lo;
      end
   end

endmodule
